adbg_jsp_rx_packer: RTL and testbench

- Serial-to-byte front end for the debug byte FIFO.
- Assembles JTAG-shifted TDI bits into bytes and pushes them into an 8-deep byte FIFO through its single EN/PUSH_POPn port.
- Arbitrates that same port for a bus-side byte consumer, and reports overflow and receive statistics.
- Sits between the JTAG TAP data-register shift path and the byte FIFO.

---
 rtl/adbg_jsp_pkg.sv | 16 +
 rtl/adbg_jsp_fifo_arbiter.sv | 28 ++
 rtl/adbg_jsp_rx_packer.sv | 108 ++++++++++
 tb/tb_adbg_jsp_rx_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_jsp_pkg.sv
// Shared types for the JTAG serial port receive path: byte geometry, FIFO level
// type and the operation issued on the byte FIFO's single EN/PUSH_POPn port.
package adbg_jsp_pkg;

  localparam int BYTE_BITS  = 8;
  localparam int FIFO_DEPTH = 8;

  typedef logic [3:0] fifo_lvl_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP
  } port_op_t;

endpackage

// File: rtl/adbg_jsp_fifo_arbiter.sv
// Combinational owner of the byte FIFO port: a pending held byte always wins,
// a consumer pop only goes out when no push is due and the FIFO has data.
module adbg_jsp_fifo_arbiter
  import adbg_jsp_pkg::*;
(
  input  logic      hold_valid,
  input  logic      pop_req,
  input  fifo_lvl_t fifo_avail,
  input  fifo_lvl_t fifo_free,
  output port_op_t  op,
  output logic      fifo_en,
  output logic      fifo_push_popn,
  output logic      pop_ack
);

  always_comb begin
    op = OP_IDLE;
    if (hold_valid && (fifo_free != '0)) begin
      op = OP_PUSH;
    end else if (pop_req && (fifo_avail != '0)) begin
      op = OP_POP;
    end
    fifo_en        = (op != OP_IDLE);
    fifo_push_popn = (op == OP_PUSH);
    pop_ack        = (op == OP_POP);
  end

endmodule

// File: rtl/adbg_jsp_rx_packer.sv
// Packs TDI bits into bytes, parks each byte in a one-entry hold stage and pushes
// it to the byte FIFO one cycle later; a full FIFO stalls the hold stage and drops later bytes.
module adbg_jsp_rx_packer
  import adbg_jsp_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SHIFT_EN,
  input  logic                 TDI_BIT,
  input  logic                 FRAME_START,
  input  logic                 POP_REQ,
  output logic                 POP_ACK,
  output logic [BYTE_BITS-1:0] POP_DATA,
  output logic [BYTE_BITS-1:0] FIFO_DIN,
  input  logic [BYTE_BITS-1:0] FIFO_DOUT,
  output logic                 FIFO_EN,
  output logic                 FIFO_PUSH_POPn,
  input  fifo_lvl_t            FIFO_AVAIL,
  input  fifo_lvl_t            FIFO_FREE,
  output logic                 OVERFLOW,
  input  logic                 OVERFLOW_CLR,
  output logic [2:0]           BIT_CNT,
  output logic [CNT_WIDTH-1:0] BYTES_RCVD
);

  logic [2:0]           bit_cnt;
  logic [BYTE_BITS-1:0] shift_reg;
  logic [BYTE_BITS-1:0] hold_reg;
  logic                 hold_valid;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] bytes_rcvd;

  port_op_t             op;
  logic                 push_now;
  logic [2:0]           base_cnt;
  logic [BYTE_BITS-1:0] base_sr;
  logic [BYTE_BITS-1:0] next_sr;
  logic                 byte_done;

  adbg_jsp_fifo_arbiter u_arb (
    .hold_valid     (hold_valid),
    .pop_req        (POP_REQ),
    .fifo_avail     (FIFO_AVAIL),
    .fifo_free      (FIFO_FREE),
    .op             (op),
    .fifo_en        (FIFO_EN),
    .fifo_push_popn (FIFO_PUSH_POPn),
    .pop_ack        (POP_ACK)
  );

  assign push_now = (op == OP_PUSH);

  // A frame start realigns before the same-cycle bit is taken, so that bit opens a new byte.
  always_comb begin
    base_cnt  = FRAME_START ? 3'd0 : bit_cnt;
    base_sr   = FRAME_START ? '0 : shift_reg;
    next_sr   = LSB_FIRST ? {TDI_BIT, base_sr[BYTE_BITS-1:1]}
                          : {base_sr[BYTE_BITS-2:0], TDI_BIT};
    byte_done = SHIFT_EN && (base_cnt == 3'd7);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      overflow   <= 1'b0;
      bytes_rcvd <= '0;
    end else begin
      if (SHIFT_EN) begin
        bit_cnt   <= base_cnt + 3'd1;
        shift_reg <= next_sr;
      end else if (FRAME_START) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end

      // The hold slot is free for a new byte if it is empty or being drained this edge.
      if (byte_done && (!hold_valid || push_now)) begin
        hold_reg   <= next_sr;
        hold_valid <= 1'b1;
      end else if (push_now) begin
        hold_valid <= 1'b0;
      end

      if (push_now) begin
        bytes_rcvd <= bytes_rcvd + CNT_WIDTH'(1);
      end

      if (byte_done && hold_valid && !push_now) begin
        overflow <= 1'b1;
      end else if (OVERFLOW_CLR) begin
        overflow <= 1'b0;
      end
    end
  end

  assign FIFO_DIN   = hold_reg;
  assign POP_DATA   = FIFO_DOUT;
  assign OVERFLOW   = overflow;
  assign BIT_CNT    = bit_cnt;
  assign BYTES_RCVD = bytes_rcvd;

endmodule

// File: tb/tb_adbg_jsp_rx_packer.sv
// Directed bench for the JSP receive packer with a bit-queue reference model
// checked every cycle, plus literal checkpoints for each scenario.
module tb_adbg_jsp_rx_packer;

  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SHIFT_EN;
  logic          TDI_BIT;
  logic          FRAME_START;
  logic          POP_REQ;
  logic          POP_ACK;
  logic [7:0]    POP_DATA;
  logic [7:0]    FIFO_DIN;
  logic [7:0]    FIFO_DOUT;
  logic          FIFO_EN;
  logic          FIFO_PUSH_POPn;
  logic [3:0]    FIFO_AVAIL;
  logic [3:0]    FIFO_FREE;
  logic          OVERFLOW;
  logic          OVERFLOW_CLR;
  logic [2:0]    BIT_CNT;
  logic [CW-1:0] BYTES_RCVD;

  int n_cmp = 0;
  int n_err = 0;

  adbg_jsp_rx_packer #(.LSB_FIRST(1'b1), .CNT_WIDTH(CW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .SHIFT_EN       (SHIFT_EN),
    .TDI_BIT        (TDI_BIT),
    .FRAME_START    (FRAME_START),
    .POP_REQ        (POP_REQ),
    .POP_ACK        (POP_ACK),
    .POP_DATA       (POP_DATA),
    .FIFO_DIN       (FIFO_DIN),
    .FIFO_DOUT      (FIFO_DOUT),
    .FIFO_EN        (FIFO_EN),
    .FIFO_PUSH_POPn (FIFO_PUSH_POPn),
    .FIFO_AVAIL     (FIFO_AVAIL),
    .FIFO_FREE      (FIFO_FREE),
    .OVERFLOW       (OVERFLOW),
    .OVERFLOW_CLR   (OVERFLOW_CLR),
    .BIT_CNT        (BIT_CNT),
    .BYTES_RCVD     (BYTES_RCVD)
  );

  always #5 CLK = ~CLK;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: received bits as a list, a single held byte, counters as integers.
  bit         m_bits[$];
  logic [7:0] m_hold = 8'h00;
  bit         m_hold_vld = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_cnt = 0;
  bit         m_init = 1'b0;

  function automatic bit model_push();
    return m_hold_vld && (FIFO_FREE != 4'd0);
  endfunction

  always @(posedge CLK) begin
    bit         push;
    bit         done;
    logic [7:0] b;
    if (RST) begin
      m_bits.delete();
      m_hold     = 8'h00;
      m_hold_vld = 1'b0;
      m_ovf      = 1'b0;
      m_cnt      = 0;
      m_init     = 1'b1;
    end else if (m_init) begin
      push = model_push();
      done = 1'b0;
      b    = 8'h00;
      if (FRAME_START) m_bits.delete();
      if (SHIFT_EN) begin
        m_bits.push_back(TDI_BIT);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) b[i] = m_bits[i];
          done = 1'b1;
          m_bits.delete();
        end
      end
      if (push) begin
        m_hold_vld = 1'b0;
        m_cnt++;
      end
      if (done) begin
        if (!m_hold_vld) begin
          m_hold     = b;
          m_hold_vld = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (OVERFLOW_CLR) begin
        m_ovf = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    bit ep;
    bit eo;
    if (m_init) begin
      ep = model_push();
      eo = POP_REQ && !ep && (FIFO_AVAIL != 4'd0);
      check("m_fifo_en", FIFO_EN, ep || eo);
      check("m_push_popn", FIFO_PUSH_POPn, ep);
      check("m_pop_ack", POP_ACK, eo);
      check("m_fifo_din", FIFO_DIN, m_hold);
      if (eo) check("m_pop_data", POP_DATA, FIFO_DOUT);
      check("m_bit_cnt", BIT_CNT, m_bits.size());
      check("m_overflow", OVERFLOW, m_ovf);
      check("m_bytes_rcvd", BYTES_RCVD, m_cnt % (1 << CW));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      SHIFT_EN = 1'b1;
      TDI_BIT  = b[i];
      cyc();
    end
    SHIFT_EN = 1'b0;
    TDI_BIT  = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    RST = 1'b1; SHIFT_EN = 1'b0; TDI_BIT = 1'b0; FRAME_START = 1'b0;
    POP_REQ = 1'b0; OVERFLOW_CLR = 1'b0; FIFO_DOUT = 8'h00;
    FIFO_AVAIL = 4'd0; FIFO_FREE = 4'd8;
    cyc(); cyc();
    RST = 1'b0; #1;
    check("rst_bit_cnt", BIT_CNT, 0);
    check("rst_fifo_en", FIFO_EN, 0);
    check("rst_bytes", BYTES_RCVD, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_din", FIFO_DIN, 0);

    // Single byte, push one cycle after the 8th bit.
    shift_byte(8'hA5); #1;
    check("a5_en", FIFO_EN, 1);
    check("a5_pp", FIFO_PUSH_POPn, 1);
    check("a5_din", FIFO_DIN, 8'hA5);
    check("a5_bit_cnt", BIT_CNT, 0);
    check("a5_bytes_pre", BYTES_RCVD, 0);
    cyc(); #1;
    check("a5_bytes", BYTES_RCVD, 1);
    check("a5_idle", FIFO_EN, 0);

    // Fill, then full FIFO: first byte held, second dropped.
    for (int i = 0; i < 8; i++) shift_byte(8'(i));
    cyc();
    FIFO_FREE = 4'd0;
    shift_byte(8'h3C); #1;
    check("full_no_push", FIFO_EN, 0);
    check("full_din", FIFO_DIN, 8'h3C);
    shift_byte(8'hC3); #1;
    check("ovf_set", OVERFLOW, 1);
    check("ovf_kept_oldest", FIFO_DIN, 8'h3C);
    check("ovf_bytes", BYTES_RCVD, 9);
    FIFO_FREE = 4'd1; #1;
    check("release_en", FIFO_EN, 1);
    check("release_pp", FIFO_PUSH_POPn, 1);
    check("release_din", FIFO_DIN, 8'h3C);
    cyc(); #1;
    check("release_bytes", BYTES_RCVD, 10);
    OVERFLOW_CLR = 1'b1;
    cyc();
    OVERFLOW_CLR = 1'b0; #1;
    check("ovf_clr", OVERFLOW, 0);
    FIFO_FREE = 4'd8;

    // Pop collides with push: pop deferred one cycle.
    shift_byte(8'h5A);
    POP_REQ = 1'b1; FIFO_AVAIL = 4'd2; FIFO_DOUT = 8'h77; #1;
    check("coll_pp", FIFO_PUSH_POPn, 1);
    check("coll_ack", POP_ACK, 0);
    check("coll_din", FIFO_DIN, 8'h5A);
    cyc(); #1;
    check("pop_ack", POP_ACK, 1);
    check("pop_en", FIFO_EN, 1);
    check("pop_pp", FIFO_PUSH_POPn, 0);
    check("pop_data", POP_DATA, 8'h77);
    check("pop_bytes", BYTES_RCVD, 11);
    POP_REQ = 1'b0; FIFO_AVAIL = 4'd0;

    // Five junk bits, then realign with a bit in the same cycle.
    for (int i = 0; i < 5; i++) begin
      SHIFT_EN = 1'b1; TDI_BIT = 1'b1; cyc();
    end
    FRAME_START = 1'b1; TDI_BIT = 1'b0; cyc();
    FRAME_START = 1'b0; SHIFT_EN = 1'b0; #1;
    check("fs_bit_cnt", BIT_CNT, 1);
    v = 8'h96;
    for (int i = 1; i < 8; i++) begin
      SHIFT_EN = 1'b1; TDI_BIT = v[i]; cyc();
    end
    SHIFT_EN = 1'b0; #1;
    check("fs_din", FIFO_DIN, 8'h96);
    check("fs_en", FIFO_EN, 1);
    cyc(); #1;
    check("fs_bytes", BYTES_RCVD, 12);

    // Reset with a held byte and a partial byte in flight.
    FIFO_FREE = 4'd0;
    shift_byte(8'hE1);
    for (int i = 0; i < 3; i++) begin
      SHIFT_EN = 1'b1; TDI_BIT = 1'b1; cyc();
    end
    SHIFT_EN = 1'b0; #1;
    check("prerst_bit_cnt", BIT_CNT, 3);
    check("prerst_din", FIFO_DIN, 8'hE1);
    RST = 1'b1; cyc();
    RST = 1'b0; FIFO_FREE = 4'd8; #1;
    check("midrst_bit_cnt", BIT_CNT, 0);
    check("midrst_bytes", BYTES_RCVD, 0);
    check("midrst_ovf", OVERFLOW, 0);
    check("midrst_en", FIFO_EN, 0);
    repeat (3) cyc();
    check("midrst_no_push", FIFO_EN, 0);

    // Counter wraps after 2^CW pushes; pop on empty FIFO is refused.
    for (int i = 0; i < (1 << CW); i++) shift_byte(8'(i));
    #1;
    check("wrap_pre", BYTES_RCVD, (1 << CW) - 1);
    cyc(); #1;
    check("wrap", BYTES_RCVD, 0);
    POP_REQ = 1'b1; FIFO_AVAIL = 4'd0; #1;
    check("empty_ack", POP_ACK, 0);
    check("empty_en", FIFO_EN, 0);
    cyc(); #1;
    check("empty_ack2", POP_ACK, 0);
    POP_REQ = 1'b0;

    // Overflow set beats a simultaneous clear.
    FIFO_FREE = 4'd0;
    shift_byte(8'h11);
    OVERFLOW_CLR = 1'b1;
    shift_byte(8'h22); #1;
    check("set_wins", OVERFLOW, 1);
    OVERFLOW_CLR = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
